// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers one load/store request at a time.
// Each request gets a fixed, programmable latency before its response is presented.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          op_we;
    logic          op_err;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic [IW-1:0] op_idx;

    assign accept = (state == IDLE) && req_valid;

    // With no wait the access happens on the acceptance edge itself, so the
    // live request is used; otherwise the copy latched at acceptance.
    always_comb begin
        op_we    = lat_we;
        op_addr  = lat_addr;
        op_wdata = lat_wdata;
        op_be    = lat_be;
        if (state == IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_be    = req_be;
        end
        enter_resp = (accept && NO_WAIT) || ((state == BUSY) && (cnt == 4'd1));
        op_err     = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
        op_idx     = op_addr[IW+1:2];
    end

    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        req_ready <= 1'b0;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Shared RESP entry from either IDLE (no wait) or BUSY; overrides the above.
            if (enter_resp) begin
                state      <= RESP;
                cnt        <= '0;
                req_ready  <= 1'b0;
                resp_valid <= 1'b1;
                resp_err   <= op_err;
                resp_rdata <= (op_we || op_err) ? '0 : mem[op_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array memory model.
// Instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0 for back-to-back traffic.
module tb_data_mem_responder;

    localparam int A_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_a [256];
    logic [31:0] model_b [8];

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    function automatic logic exp_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr / 4 >= 256);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] be);
        logic [31:0] mask = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old & ~mask) | (wdata & mask);
    endfunction

    function automatic logic [31:0] model_result(input logic we, input logic [31:0] addr);
        if (we || exp_err(addr)) return 32'h0;
        return model_a[addr / 4];
    endfunction

    function automatic void model_store(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be);
        if (we && !exp_err(addr)) model_a[addr / 4] = merge(model_a[addr / 4], wdata, be);
    endfunction

    task automatic scramble_a;
        a_req_we    = 1'($urandom);
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        a_req_be    = 4'($urandom);
    endtask

    // Drives one request on instance a with resp_ready high; returns latency in
    // rising edges from acceptance to the first edge seeing resp_valid.
    task automatic issue_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int lat, output logic [31:0] rd,
                           output logic er);
        int n;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = wdata; a_req_be = be; a_resp_ready = 1'b1;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0;
        scramble_a();
        lat = 1;
        while (a_resp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        rd = a_resp_rdata;
        er = a_resp_err;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        a_req_valid = 1'b0; a_resp_ready = 1'b1; scramble_a();
        b_req_valid = 1'b0; b_resp_ready = 1'b1;
        b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        repeat (3) @(negedge clk);
        checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", a_resp_rdata); end
        checks++; if (a_resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", a_resp_err); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b expected 1", a_req_ready); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready got %b expected 1", b_req_ready); end
    endtask

    task automatic test_fill;
        int lat; logic [31:0] rd, d; logic er;
        for (int w = 0; w < 256; w++) begin
            d = $urandom;
            issue_a(1'b1, 32'(w * 4), d, 4'hF, lat, rd, er);
            model_store(1'b1, 32'(w * 4), d, 4'hF);
            checks++; if (lat != A_LAT) begin errors++; $display("FAIL fill_latency w=%0d got %0d expected %0d", w, lat, A_LAT); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL fill_err w=%0d got %b expected 0", w, er); end
        end
    endtask

    task automatic test_directed;
        int lat; logic [31:0] rd; logic er;
        issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
        model_store(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (lat != 3) begin errors++; $display("FAIL store10_latency got %0d expected 3", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store10_resp got err=%b rdata=%h expected 0/0", er, rd); end
        issue_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        checks++; if (lat != 3) begin errors++; $display("FAIL load10_latency got %0d expected 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load10_data got %h err=%b expected deadbeef err=0", rd, er); end
        checks++; if (a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0 || a_req_ready !== 1'b1 || a_resp_valid !== 1'b0)
            begin errors++; $display("FAIL idle_clear got rdata=%h err=%b ready=%b valid=%b expected 0/0/1/0", a_resp_rdata, a_resp_err, a_req_ready, a_resp_valid); end

        issue_a(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
        issue_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
        model_store(1'b1, 32'h20, 32'h11223344, 4'hF);
        model_store(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        issue_a(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable got %h expected 11bb33dd", rd); end

        issue_a(1'b0, 32'h22, 32'h0, 4'hF, lat, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_load got err=%b rdata=%h expected 1/0", er, rd); end
        issue_a(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL range_store got err=%b rdata=%h expected 1/0", er, rd); end
        issue_a(1'b1, 32'h0, 32'h5A5A5A5A, 4'h0, lat, rd, er);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0_store_err got %b expected 0", er); end
        for (int w = 0; w < 256; w++) begin
            issue_a(1'b0, 32'(w * 4), 32'h0, 4'h0, lat, rd, er);
            checks++; if (rd !== model_a[w]) begin errors++; $display("FAIL sweep w=%0d got %h expected %h", w, rd, model_a[w]); end
        end
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd, addr, wdata, exp_rd; logic er, we; logic [3:0] be; int kind;
        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 6)      addr = 32'($urandom_range(0, 255) * 4);
            else if (kind == 7) addr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else if (kind == 8) addr = 32'(($urandom_range(256, 2000)) * 4);
            else                addr = $urandom;
            we = 1'($urandom); wdata = $urandom; be = 4'($urandom);
            exp_rd = model_result(we, addr);
            issue_a(we, addr, wdata, be, lat, rd, er);
            model_store(we, addr, wdata, be);
            checks++; if (lat != A_LAT) begin errors++; $display("FAIL rand_latency t=%0d got %0d expected %0d", t, lat, A_LAT); end
            checks++; if (er !== exp_err(addr)) begin errors++; $display("FAIL rand_err t=%0d addr=%h got %b expected %b", t, addr, er, exp_err(addr)); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata t=%0d addr=%h got %h expected %h", t, addr, rd, exp_rd); end
        end
    endtask

    task automatic test_backpressure;
        int n, lat; logic [31:0] d, rd; logic [3:0] be; logic er;
        d = $urandom; be = 4'($urandom_range(1, 15));
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h14;
        a_req_wdata = d; a_req_be = be; a_resp_ready = 1'b0;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0; scramble_a();
        n = 0;
        while (a_resp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        model_store(1'b1, 32'h14, d, be);
        for (int i = 0; i < 10; i++) begin
            checks++; if (a_resp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid i=%0d got %b expected 1", i, a_resp_valid); end
            checks++; if (a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0) begin errors++; $display("FAIL hold_resp i=%0d got rdata=%h err=%b expected 0/0", i, a_resp_rdata, a_resp_err); end
            checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready i=%0d got %b expected 0", i, a_req_ready); end
            @(negedge clk);
            a_req_valid = 1'($urandom); scramble_a();
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready=%b expected 0/1", a_resp_valid, a_req_ready); end
        issue_a(1'b0, 32'h14, 32'h0, 4'h0, lat, rd, er);
        checks++; if (rd !== model_a[5]) begin errors++; $display("FAIL hold_readback got %h expected %h", rd, model_a[5]); end
    endtask

    task automatic test_reset_busy;
        int n, lat; logic [31:0] rd; logic er;
        issue_a(1'b1, 32'h30, 32'h12345678, 4'hF, lat, rd, er);
        model_store(1'b1, 32'h30, 32'h12345678, 4'hF);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h30;
        a_req_wdata = 32'h55; a_req_be = 4'hF; a_resp_ready = 1'b1;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0)
            begin errors++; $display("FAIL busy_reset got valid=%b rdata=%h err=%b expected 0/0/0", a_resp_valid, a_resp_rdata, a_resp_err); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue_a(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL busy_reset_mem got %h expected 12345678", rd); end
    endtask

    task automatic test_reset_resp;
        int n, lat; logic [31:0] rd; logic er;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h34;
        a_req_wdata = 32'hCAFEF00D; a_req_be = 4'hF; a_resp_ready = 1'b0;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (a_resp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        model_store(1'b1, 32'h34, 32'hCAFEF00D, 4'hF);
        rst = 1'b0;
        #1;
        checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL resp_reset got valid=%b expected 0", a_resp_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b1; a_resp_ready = 1'b1;
        issue_a(1'b0, 32'h34, 32'h0, 4'h0, lat, rd, er);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL resp_reset_mem got %h expected cafef00d", rd); end
    endtask

    task automatic test_back_to_back;
        int cyc, acc_prev, n, word; logic [31:0] wdata, exp_rd; logic we;
        cyc = 0; acc_prev = 0;
        @(negedge clk);
        b_resp_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            we = (k < 8);
            word = (k < 8) ? k : int'($urandom_range(0, 7));
            wdata = $urandom;
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = 32'(word * 4);
            b_req_wdata = wdata; b_req_be = 4'hF;
            n = 0;
            while (b_req_ready !== 1'b1 && n < 20) begin @(negedge clk); cyc++; n++; end
            if (k > 0) begin
                checks++; if (cyc - acc_prev != 2) begin errors++; $display("FAIL b2b_interval k=%0d got %0d expected 2", k, cyc - acc_prev); end
            end
            acc_prev = cyc;
            exp_rd = we ? 32'h0 : model_b[word];
            if (we) model_b[word] = wdata;
            @(negedge clk); cyc++;
            checks++; if (b_resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got %b expected 1", k, b_resp_valid); end
            checks++; if (b_resp_rdata !== exp_rd || b_resp_err !== 1'b0) begin errors++; $display("FAIL b2b_resp k=%0d got %h err=%b expected %h err=0", k, b_resp_rdata, b_resp_err, exp_rd); end
        end
        b_req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_busy();
        test_reset_resp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
